// File: rtl/moldudp64_pkg.sv
// Shared MoldUDP64 constants, request FSM state type and wire byte-order helper.
package moldudp64_pkg;

    localparam int unsigned MOLD_REQ_LEN = 20;
    localparam int unsigned MOLD_SID_LEN = 10;
    localparam int unsigned MOLD_SEQ_LEN = 8;
    localparam int unsigned MOLD_CNT_LEN = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } req_fsm_e;

    // Big-endian word to beat layout: byte 0 of the beat sits on bits [7:0].
    function automatic logic [63:0] be_to_beat(input logic [63:0] be);
        logic [63:0] beat;
        for (int k = 0; k < 8; k++) begin
            beat[8*k +: 8] = be[56 - 8*k +: 8];
        end
        return beat;
    endfunction

endpackage

// File: rtl/miss_req_gen.sv
// MoldUDP64 retransmission request generator: turns one missed-range event into one or more
// 20-byte request packets emitted as three 64-bit beats each.
module miss_req_gen
    import moldudp64_pkg::*;
#(
    parameter int unsigned SEQ_NUM_W   = 18,
    parameter int unsigned SID_W       = 80,
    parameter logic [15:0] MAX_REQ_CNT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 miss_v_i,
    output logic                 miss_ready_o,
    input  logic [SID_W-1:0]     miss_sid_i,
    input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
    input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
    output logic                 req_v_o,
    input  logic                 req_ready_i,
    output logic [63:0]          req_data_o,
    output logic [7:0]           req_keep_o,
    output logic                 req_last_o
);

    req_fsm_e               state_q, state_d;
    logic [SID_W-1:0]       sid_q, sid_d;
    logic [SEQ_NUM_W-1:0]   start_q, start_d;
    logic [SEQ_NUM_W-1:0]   cnt_q, cnt_d;

    logic [63:0]            cnt64;
    logic [63:0]            reqc64;
    logic [15:0]            reqc16;
    logic [SEQ_NUM_W-1:0]   reqc_w;
    logic [63:0]            seq64;
    logic [63:0]            be_word;

    // Split arithmetic done at 64 bits so any SEQ_NUM_W compares cleanly against the 16-bit cap.
    always_comb begin
        cnt64  = 64'(cnt_q);
        reqc64 = (cnt64 > 64'(MAX_REQ_CNT)) ? 64'(MAX_REQ_CNT) : cnt64;
        reqc16 = reqc64[15:0];
        reqc_w = SEQ_NUM_W'(reqc64);
        seq64  = 64'(start_q);
    end

    always_comb begin
        state_d = state_q;
        sid_d   = sid_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (miss_v_i) begin
                    sid_d   = miss_sid_i;
                    start_d = miss_seq_start_i;
                    cnt_d   = miss_cnt_i;
                    if (miss_cnt_i != '0) begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: if (req_ready_i) state_d = BEAT1;
            BEAT1: if (req_ready_i) state_d = BEAT2;
            BEAT2: begin
                if (req_ready_i) begin
                    cnt_d   = cnt_q - reqc_w;
                    start_d = start_q + reqc_w;
                    state_d = (cnt_d != '0) ? BEAT0 : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sid_q   <= '0;
            start_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sid_q   <= sid_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        be_word      = '0;
        req_keep_o   = 8'h00;
        req_last_o   = 1'b0;
        req_v_o      = 1'b0;
        miss_ready_o = 1'b0;
        unique case (state_q)
            IDLE: miss_ready_o = 1'b1;
            BEAT0: begin
                be_word    = sid_q[79:16];
                req_keep_o = 8'hFF;
                req_v_o    = 1'b1;
            end
            BEAT1: begin
                be_word    = {sid_q[15:0], seq64[63:16]};
                req_keep_o = 8'hFF;
                req_v_o    = 1'b1;
            end
            BEAT2: begin
                be_word    = {seq64[15:0], reqc16, 32'h0};
                req_keep_o = 8'h0F;
                req_last_o = 1'b1;
                req_v_o    = 1'b1;
            end
        endcase
        req_data_o = be_to_beat(be_word);
    end

endmodule
